// File: rtl/alu_issue_if.sv
// Instruction handshake and ALU operand/result bus for the issue unit.
// Valid/ready: a transfer happens on a rising clk edge where both
// instr_valid and instr_ready are high; instr must be stable while valid.
`timescale 1ns/1ps
interface alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_z;
  logic        alu_c;
  logic        alu_n;
  logic        alu_o;

  // Issue unit side
  modport slave (
    input  instr_valid, instr, alu_result, alu_z, alu_c, alu_n, alu_o,
    output instr_ready, alu_a, alu_b, alu_op
  );

  // Instruction source plus ALU side
  modport master (
    output instr_valid, instr, alu_result, alu_z, alu_c, alu_n, alu_o,
    input  instr_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around an external combinational ALU.
// Operands come from an 8x16 register file with forwarding from the
// single writeback (W) register; W commits one edge after acceptance.
// After reset the register file is cleared one entry per cycle.
`timescale 1ns/1ps
module alu_issue_unit #(
  parameter int NREGS       = 8,
  parameter int INIT_CYCLES = NREGS
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus,
  output logic [3:0]  flags,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        dbg_state
);

  localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           instr_ready_q;
  logic [3:0]     flags_q;
  logic           illegal_q;
  logic [15:0]    regs_q [NREGS];

  // Writeback stage
  logic           w_valid_q;
  logic           w_wen_q;
  logic           w_flen_q;
  logic [2:0]     w_rd_q;
  logic [15:0]    w_data_q;
  logic [3:0]     w_flags_q;

  // Decode
  logic [3:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic        is_alu, is_ldi, is_rsvd, accept, init_done;
  logic [15:0] imm_sext;
  logic [15:0] w_data_d;

  assign op        = bus.instr[15:12];
  assign rd        = bus.instr[11:9];
  assign rs1       = bus.instr[8:6];
  assign rs2       = bus.instr[5:3];
  assign is_alu    = ~op[3];
  assign is_ldi    = (op == 4'b1000);
  assign is_rsvd   = op[3] & ~is_ldi;
  assign imm_sext  = {{7{bus.instr[8]}}, bus.instr[8:0]};
  assign accept    = bus.instr_valid & instr_ready_q;
  assign init_done = (cnt_q == CW'(INIT_CYCLES - 1));

  // Operand selection with independent forwarding per operand from W
  always_comb begin
    bus.alu_a = regs_q[rs1];
    bus.alu_b = regs_q[rs2];
    if (w_valid_q && w_wen_q && (w_rd_q == rs1)) bus.alu_a = w_data_q;
    if (w_valid_q && w_wen_q && (w_rd_q == rs2)) bus.alu_b = w_data_q;
  end

  assign bus.alu_op      = is_alu ? op : 4'b0000;
  assign bus.instr_ready = instr_ready_q;
  assign flags           = flags_q;
  assign illegal         = illegal_q;
  assign dbg_data        = regs_q[dbg_addr];
  assign dbg_state       = (state_q == S_RUN);

  // Data captured into W: immediate for LDI, ALU result otherwise
  always_comb begin
    w_data_d = bus.alu_result;
    if (is_ldi) w_data_d = imm_sext;
  end

  // FSM, writeback capture and flag commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      instr_ready_q <= 1'b0;
      flags_q       <= 4'b0000;
      illegal_q     <= 1'b0;
      w_valid_q     <= 1'b0;
      w_wen_q       <= 1'b0;
      w_flen_q      <= 1'b0;
      w_rd_q        <= 3'd0;
      w_data_q      <= 16'h0000;
      w_flags_q     <= 4'b0000;
    end else begin
      illegal_q <= accept & is_rsvd;
      w_valid_q <= accept;
      w_wen_q   <= accept & ~is_rsvd;
      w_flen_q  <= accept & is_alu;
      w_rd_q    <= rd;
      w_data_q  <= w_data_d;
      w_flags_q <= {bus.alu_z, bus.alu_c, bus.alu_n, bus.alu_o};
      if (w_valid_q && w_flen_q) flags_q <= w_flags_q;
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (init_done) begin
            state_q       <= S_RUN;
            cnt_q         <= '0;
            instr_ready_q <= 1'b1;
          end
        end
        S_RUN: instr_ready_q <= 1'b1;
        default: begin
          state_q       <= S_INIT;
          cnt_q         <= '0;
          instr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Register file: clear during INIT, otherwise commit from W; frozen in reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) regs_q[3'(cnt_q)] <= 16'h0000;
      else if (w_valid_q && w_wen_q) regs_q[w_rd_q] <= w_data_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU attached.
`timescale 1ns/1ps
module tb_alu_issue_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  flags;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_regs [8];

  alu_issue_if bus();

  alu_issue_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flags     (flags),
    .illegal   (illegal),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: Z zero, C carry/borrow/shifted-out bit, N sign, O signed overflow
  always_comb begin
    logic [16:0] wide;
    logic [15:0] a, b, r;
    logic        c, o;
    a = bus.alu_a;
    b = bus.alu_b;
    wide = 17'd0;
    r = 16'h0000;
    c = 1'b0;
    o = 1'b0;
    case (bus.alu_op)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[15:0]; c = wide[16];
                  o = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin wide = {1'b0, a} - {1'b0, b}; r = wide[15:0]; c = wide[16];
                  o = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = {a[14:0], 1'b0}; c = a[15]; end
      4'd7: begin r = {1'b0, a[15:1]}; c = a[0]; end
      default: r = 16'h0000;
    endcase
    bus.alu_result = r;
    bus.alu_z = (r == 16'h0000);
    bus.alu_c = c;
    bus.alu_n = r[15];
    bus.alu_o = o;
  end

  // Counts negedges from the current one until instr_ready rises (bounded)
  task automatic wait_ready(output int n);
    n = 0;
    #1;
    while (!bus.instr_ready && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int n;
    @(negedge clk);
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr = 16'hF000;
    repeat (3) @(negedge clk);
    #1;
    vec_cnt++;
    if (bus.instr_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b expected 0", bus.instr_ready); end
    vec_cnt++;
    if (flags !== 4'b0000) begin err_cnt++; $display("FAIL rst_flags: got %b expected 0000", flags); end
    vec_cnt++;
    if (illegal !== 1'b0) begin err_cnt++; $display("FAIL rst_illegal: got %b expected 0", illegal); end
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    bus.instr_valid = 1'b0;
    vec_cnt++;
    if (n !== 8) begin err_cnt++; $display("FAIL init_len: got %0d cycles expected 8", n); end
    vec_cnt++;
    if (dbg_state !== 1'b1) begin err_cnt++; $display("FAIL init_state: got %b expected 1", dbg_state); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      vec_cnt++;
      if (dbg_data !== 16'h0000) begin err_cnt++; $display("FAIL init_r%0d: got %h expected 0000", i, dbg_data); end
      exp_regs[i] = 16'h0000;
    end
    vec_cnt++;
    if (flags !== 4'b0000) begin err_cnt++; $display("FAIL init_flags: got %b expected 0000", flags); end
  endtask

  task automatic test_fwd_add;
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'h8205;  // LDI R1,5
    @(negedge clk); bus.instr = 16'h8403;                          // LDI R2,3
    @(negedge clk); bus.instr = 16'h0650;                          // ADD R3,R1,R2
    #1;
    vec_cnt++;
    if (bus.alu_a !== 16'h0005) begin err_cnt++; $display("FAIL add_a: got %h expected 0005", bus.alu_a); end
    vec_cnt++;
    if (bus.alu_b !== 16'h0003) begin err_cnt++; $display("FAIL add_b_fwd: got %h expected 0003", bus.alu_b); end
    vec_cnt++;
    if (bus.alu_op !== 4'd0) begin err_cnt++; $display("FAIL add_op: got %h expected 0", bus.alu_op); end
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk); #1;
    exp_regs[1] = 16'h0005; exp_regs[2] = 16'h0003; exp_regs[3] = 16'h0008;
    for (int i = 1; i < 4; i++) begin
      dbg_addr = 3'(i);
      #1;
      vec_cnt++;
      if (dbg_data !== exp_regs[i]) begin err_cnt++; $display("FAIL add_r%0d: got %h expected %h", i, dbg_data, exp_regs[i]); end
    end
    vec_cnt++;
    if (flags !== 4'b0000) begin err_cnt++; $display("FAIL add_flags: got %b expected 0000", flags); end
  endtask

  task automatic test_ldi_sub;
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'h89FF;  // LDI R4,-1
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    dbg_addr = 3'd4;
    #1;
    exp_regs[4] = 16'hFFFF;
    vec_cnt++;
    if (dbg_data !== 16'hFFFF) begin err_cnt++; $display("FAIL ldi_neg: got %h expected ffff", dbg_data); end
    vec_cnt++;
    if (flags !== 4'b0000) begin err_cnt++; $display("FAIL ldi_flags: got %b expected 0000", flags); end
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'h1A48;  // SUB R5,R1,R1
    #1;
    vec_cnt++;
    if (bus.alu_op !== 4'd1) begin err_cnt++; $display("FAIL sub_op: got %h expected 1", bus.alu_op); end
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    dbg_addr = 3'd5;
    #1;
    exp_regs[5] = 16'h0000;
    vec_cnt++;
    if (dbg_data !== 16'h0000) begin err_cnt++; $display("FAIL sub_r5: got %h expected 0000", dbg_data); end
    vec_cnt++;
    if (flags !== 4'b1000) begin err_cnt++; $display("FAIL sub_flags: got %b expected 1000", flags); end
  endtask

  task automatic test_reserved;
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'hA000;
    #1;
    vec_cnt++;
    if (illegal !== 1'b0) begin err_cnt++; $display("FAIL rsv_pre: got %b expected 0", illegal); end
    @(negedge clk); bus.instr_valid = 1'b0;
    #1;
    vec_cnt++;
    if (illegal !== 1'b1) begin err_cnt++; $display("FAIL rsv_pulse: got %b expected 1", illegal); end
    @(negedge clk); #1;
    vec_cnt++;
    if (illegal !== 1'b0) begin err_cnt++; $display("FAIL rsv_post: got %b expected 0", illegal); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      vec_cnt++;
      if (dbg_data !== exp_regs[i]) begin err_cnt++; $display("FAIL rsv_r%0d: got %h expected %h", i, dbg_data, exp_regs[i]); end
    end
    vec_cnt++;
    if (flags !== 4'b1000) begin err_cnt++; $display("FAIL rsv_flags: got %b expected 1000", flags); end
  endtask

  task automatic test_reset_pending;
    int n;
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'h0C50;  // ADD R6,R1,R2
    @(negedge clk); bus.instr_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    dbg_addr = 3'd6;
    #1;
    vec_cnt++;
    if (dbg_data !== 16'h0000) begin err_cnt++; $display("FAIL rp_r6: got %h expected 0000", dbg_data); end
    vec_cnt++;
    if (flags !== 4'b0000) begin err_cnt++; $display("FAIL rp_flags: got %b expected 0000", flags); end
    wait_ready(n);
    vec_cnt++;
    if (n !== 8) begin err_cnt++; $display("FAIL rp_init_len: got %0d cycles expected 8", n); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      exp_regs[i] = 16'h0000;
      vec_cnt++;
      if (dbg_data !== 16'h0000) begin err_cnt++; $display("FAIL rp_r%0d: got %h expected 0000", i, dbg_data); end
    end
  endtask

  task automatic test_idle_gap;
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'h8205;  // LDI R1,5
    @(negedge clk); bus.instr = 16'h8403;                          // LDI R2,3
    @(negedge clk); bus.instr = 16'h4E50;                          // XOR R7,R1,R2
    #1;
    vec_cnt++;
    if (bus.alu_b !== 16'h0003) begin err_cnt++; $display("FAIL xor_b_fwd: got %h expected 0003", bus.alu_b); end
    @(negedge clk); bus.instr_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      dbg_addr = 3'd7;
      #1;
      vec_cnt++;
      if (dbg_data !== 16'h0006) begin err_cnt++; $display("FAIL gap_r7_%0d: got %h expected 0006", g, dbg_data); end
      dbg_addr = 3'd0;
      #1;
      vec_cnt++;
      if (dbg_data !== 16'h0000) begin err_cnt++; $display("FAIL gap_r0_%0d: got %h expected 0000", g, dbg_data); end
    end
    @(negedge clk); bus.instr_valid = 1'b1; bus.instr = 16'h51C0;  // NOT R0,R7
    #1;
    vec_cnt++;
    if (bus.alu_a !== 16'h0006) begin err_cnt++; $display("FAIL not_a: got %h expected 0006", bus.alu_a); end
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    dbg_addr = 3'd0;
    #1;
    vec_cnt++;
    if (dbg_data !== 16'hFFF9) begin err_cnt++; $display("FAIL not_r0: got %h expected fff9", dbg_data); end
    vec_cnt++;
    if (flags !== 4'b0010) begin err_cnt++; $display("FAIL not_flags: got %b expected 0010", flags); end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    dbg_addr = 3'd0;
    test_reset;
    test_fwd_add;
    test_ldi_sub;
    test_reserved;
    test_reset_pending;
    test_idle_gap;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Issue and writeback stage for the 16-bit processor, directly upstream and downstream of the ALU. Accepts 16-bit instructions over a valid/ready handshake, reads operands from an internal 8×16 register file with forwarding, and drives the ALU's A/B/opcode inputs. Captures the ALU result and Z/C/N/O flags into a writeback register, then commits them to the register file and the flag register one cycle later. After reset, clears the register file sequentially before accepting instructions.

## Interface
Parameters:
- NREGS, 8: register count; fixed at 8 because register fields are 3 bits.
- INIT_CYCLES, NREGS: post-reset clear duration.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  unit can accept; transfer occurs when valid&ready at a rising edge.
- instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9 (LDI only).
- alu_a  out  16  operand to ALU A.
- alu_b  out  16  operand to ALU B.
- alu_op  out  4  opcode to ALU.
- alu_result  in  16  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_z, alu_c, alu_n, alu_o  in  1 each  ALU flags.
- flags  out  4  committed {Z,C,N,O}.
- illegal  out  1  one-cycle pulse for an accepted reserved opcode.
- dbg_addr  in  3  register-file debug read address.
- dbg_data  out  16  contents of register dbg_addr (combinational read, no forwarding).

## Operation
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT (A only), 0110 SHL, 0111 SHR: ALU ops.
  - 1000 LDI: rd ← sign-extend(imm9).
  - 1001–1111: reserved.
- alu_op = instr[15:12] when op < 8, else 0000. alu_a/alu_b always carry the forwarded values of rs1/rs2, regardless of instr_valid.
- Forwarding: if the W stage is valid with wen and W.rd equals rs1 (or rs2), use W.data instead of the register-file value. Each operand is checked independently.
- On accept:
  - ALU op: W ← {valid, wen=1, rd, alu_result, flags, fl_en=1}.
  - LDI: W ← {wen=1, fl_en=0}.
  - Reserved: W ← {wen=0, fl_en=0}, and illegal pulses.
- W commit, on the next edge: if wen, regfile[rd] ← data; if fl_en, flags ← captured flags. LDI and reserved ops leave flags unchanged.
- FSM states:
  - INIT: counter 0..7; writes regfile[counter] ← 0 each cycle. instr_ready = 0.
  - RUN: instr_ready = 1. The unit never stalls in RUN.
  - Transitions: rst → INIT with counter = 0. INIT → RUN after the counter-7 write. RUN holds until rst.
- R0 is a general-purpose register, not hardwired to zero.

## Timing
- Reset values: instr_ready = 0, flags = 0000, illegal = 0, W.valid = 0.
- While rst is high, no register-file writes occur and the counter holds at 0.
- The first cycle after rst deasserts is INIT count 0. instr_ready rises in the 9th cycle after rst deasserts.
- Latency: an instruction accepted at edge k has its result in regfile and flags at edge k+1. dbg_data reflects it from the cycle after k+1.
- Back-to-back dependent instructions proceed with no bubble, via forwarding.
- illegal is high during the cycle after the accepting edge k, and low otherwise.
- Reset asserted with W valid: the pending write and flag update are discarded, and INIT restarts.
- instr_valid low in RUN: W.valid ← 0 and no commit occurs. flags and the register file hold.
- In the same cycle, W commits rd while a new instruction reads rd: forwarding supplies the value.

## Test plan
- Reset, then hold instr_valid = 1 → instr_ready is 0 for exactly 8 cycles after rst falls. Afterwards, dbg_data reads 0x0000 for all 8 registers, and flags = 0000.
- LDI R1,5; LDI R2,3; ADD R3,R1,R2, issued back-to-back → alu_a = 0x0005 and alu_b = 0x0003 during the ADD cycle via forwarding. R3 = 0x0008 and flags = {Z=0,N=0} one cycle later.
- LDI R4,-1 (imm9 = 0x1FF) → R4 = 0xFFFF and flags unchanged. Then SUB R5,R1,R1 → R5 = 0x0000, Z = 1.
- Reserved instruction 0xA000 while R0..R7 hold known values → illegal pulses for 1 cycle, and the register file and flags are unchanged.
- Issue ADD R6,R1,R2 and assert rst on the following edge → R6 is never written. After INIT completes, all registers are 0x0000.
- Idle gap (instr_valid = 0 for 3 cycles) between XOR R7,R1,R2 and NOT R0,R7 → R7 = 0x0006 and R0 = 0xFFF9. No spurious writes occur during the gap.
